sliding_puzzle: RTL and testbench

SLIDING_PUZZLE -- requirements
Module: sliding_puzzle

---
 rtl/sliding_puzzle_pkg.sv | 26 ++
 rtl/sliding_puzzle_lfsr.sv | 30 +++
 rtl/sliding_puzzle.sv | 207 ++++++++++++++++++++
 tb/tb_sliding_puzzle.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sliding_puzzle_pkg.sv
// Shared encodings for the sliding puzzle: move directions, controller states and
// the scramble LFSR constants.
package sliding_puzzle_pkg;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_UP    = 2'b10,
        DIR_DOWN  = 2'b11
    } dir_e;

    typedef enum logic {
        ST_PLAY     = 1'b0,
        ST_SCRAMBLE = 1'b1
    } state_e;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    // LEFT<->RIGHT and UP<->DOWN differ only in the low bit.
    function automatic logic [1:0] reverse_dir(input logic [1:0] dir);
        return {dir[1], ~dir[0]};
    endfunction

endpackage

// File: rtl/sliding_puzzle_lfsr.sv
// 16-bit Fibonacci LFSR shifting toward the MSB; drives scramble move selection.
// A zero seed would lock the register, so it is replaced by the default seed.
module sliding_puzzle_lfsr
    import sliding_puzzle_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic        enable_i,
    input  logic [15:0] seed_i,
    output logic [15:0] state_o
);

    logic [15:0] state_q;
    logic        feedback;

    assign feedback = ^(state_q & LFSR_TAPS);
    assign state_o  = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LFSR_DEFAULT_SEED;
        end else if (load_i) begin
            state_q <= (seed_i == 16'd0) ? LFSR_DEFAULT_SEED : seed_i;
        end else if (enable_i) begin
            state_q <= {state_q[14:0], feedback};
        end
    end

endmodule

// File: rtl/sliding_puzzle.sv
// DIM x DIM sliding tile puzzle: user moves of the blank, LFSR-driven scramble,
// solved detection and a combinational cell read port.
module sliding_puzzle
    import sliding_puzzle_pkg::*;
#(
    parameter  int DIM   = 3,
    parameter  int CNT_W = 16,
    localparam int NC    = DIM * DIM,
    localparam int IW    = $clog2(NC),
    localparam int TW    = $clog2(NC),
    localparam int RW    = $clog2(DIM)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             move_val,
    input  logic [1:0]       move_dir,
    output logic             move_rdy,
    input  logic             scr_start,
    input  logic [7:0]       scr_len,
    input  logic [15:0]      scr_seed,
    output logic             busy,
    output logic             move_done,
    output logic             move_err,
    output logic             solved,
    output logic [CNT_W-1:0] move_count,
    output logic [RW-1:0]    blank_row,
    output logic [RW-1:0]    blank_col,
    input  logic [IW-1:0]    rd_idx,
    output logic [TW-1:0]    rd_tile,
    output state_e           dbg_state
);

    localparam logic [RW-1:0] EDGE = RW'(DIM - 1);

    state_e           state_q, state_d;
    logic [TW-1:0]    board_q [NC];
    logic [TW-1:0]    board_d [NC];
    logic [RW-1:0]    br_q, br_d, bc_q, bc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d, err_q, err_d;
    logic [7:0]       rem_q, rem_d;
    logic [1:0]       prev_dir_q, prev_dir_d;
    logic             prev_vld_q, prev_vld_d;

    logic [15:0]      lfsr_state;
    logic             scr_take, user_req, scr_apply, scr_last, legal;
    logic [1:0]       cand_dir;
    logic [RW-1:0]    nb_row, nb_col;
    logic [IW-1:0]    blank_idx, nb_idx;

    function automatic logic [TW-1:0] home_tile(input int i);
        return (i == NC - 1) ? '0 : TW'(i + 1);
    endfunction

    sliding_puzzle_lfsr u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .load_i   (scr_take),
        .enable_i (state_q == ST_SCRAMBLE),
        .seed_i   (scr_seed),
        .state_o  (lfsr_state)
    );

    // A scramble request outranks a same-cycle user move; a zero length is ignored.
    assign scr_take = (state_q == ST_PLAY) && scr_start && (scr_len != 8'd0);
    assign user_req = (state_q == ST_PLAY) && move_val && !scr_take;
    assign cand_dir = (state_q == ST_SCRAMBLE) ? lfsr_state[1:0] : move_dir;

    always_comb begin
        legal  = 1'b0;
        nb_row = br_q;
        nb_col = bc_q;
        case (cand_dir)
            DIR_LEFT: begin
                legal  = (bc_q != '0);
                nb_col = bc_q - 1'b1;
            end
            DIR_RIGHT: begin
                legal  = (bc_q != EDGE);
                nb_col = bc_q + 1'b1;
            end
            DIR_UP: begin
                legal  = (br_q != '0);
                nb_row = br_q - 1'b1;
            end
            default: begin
                legal  = (br_q != EDGE);
                nb_row = br_q + 1'b1;
            end
        endcase
    end

    assign blank_idx = IW'(br_q) * IW'(DIM) + IW'(bc_q);
    assign nb_idx    = IW'(nb_row) * IW'(DIM) + IW'(nb_col);

    // Scramble never undoes its own previous move, so every applied move makes progress.
    assign scr_apply = (state_q == ST_SCRAMBLE) && legal &&
                       !(prev_vld_q && (cand_dir == reverse_dir(prev_dir_q)));
    assign scr_last  = (state_q == ST_SCRAMBLE) &&
                       ((rem_q == 8'd0) || (scr_apply && (rem_q == 8'd1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_PLAY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_PLAY:     if (scr_take) state_d = ST_SCRAMBLE;
            ST_SCRAMBLE: if (scr_last) state_d = ST_PLAY;
            default:     state_d = ST_PLAY;
        endcase
    end

    always_comb begin
        move_rdy  = (state_q == ST_PLAY);
        busy      = (state_q == ST_SCRAMBLE);
        dbg_state = state_q;
    end

    always_comb begin
        for (int i = 0; i < NC; i++) begin
            board_d[i] = board_q[i];
        end
        br_d       = br_q;
        bc_d       = bc_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        prev_dir_d = prev_dir_q;
        prev_vld_d = prev_vld_q;
        done_d     = user_req && legal;
        err_d      = user_req && !legal;

        if ((user_req && legal) || scr_apply) begin
            board_d[blank_idx] = board_q[nb_idx];
            board_d[nb_idx]    = '0;
            br_d               = nb_row;
            bc_d               = nb_col;
        end
        if (user_req && legal && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (scr_take) begin
            rem_d      = scr_len;
            prev_vld_d = 1'b0;
        end
        if (scr_apply) begin
            rem_d      = rem_q - 8'd1;
            prev_dir_d = cand_dir;
            prev_vld_d = 1'b1;
        end
        if (scr_last) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NC; i++) begin
                board_q[i] <= home_tile(i);
            end
            br_q       <= EDGE;
            bc_q       <= EDGE;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rem_q      <= 8'd0;
            prev_dir_q <= 2'b00;
            prev_vld_q <= 1'b0;
        end else begin
            for (int i = 0; i < NC; i++) begin
                board_q[i] <= board_d[i];
            end
            br_q       <= br_d;
            bc_q       <= bc_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rem_q      <= rem_d;
            prev_dir_q <= prev_dir_d;
            prev_vld_q <= prev_vld_d;
        end
    end

    always_comb begin
        solved = 1'b1;
        for (int i = 0; i < NC; i++) begin
            if (board_q[i] != home_tile(i)) solved = 1'b0;
        end
    end

    always_comb begin
        rd_tile = '0;
        if (int'(rd_idx) < NC) rd_tile = board_q[rd_idx];
    end

    assign move_done  = done_q;
    assign move_err   = err_q;
    assign move_count = cnt_q;
    assign blank_row  = br_q;
    assign blank_col  = bc_q;

endmodule

// File: tb/tb_sliding_puzzle.sv
// Bench for sliding_puzzle: directed and random moves and scrambles on a 3x3 board
// against a tile-array reference model, plus counter saturation on a 4x4 board.
module tb_sliding_puzzle;
    import sliding_puzzle_pkg::*;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic        reset;
    logic        move_val, scr_start, move_rdy, busy, move_done, move_err, solved;
    logic [1:0]  move_dir, blank_row, blank_col;
    logic [7:0]  scr_len;
    logic [15:0] scr_seed, move_count;
    logic [3:0]  rd_idx, rd_tile;
    state_e      dbg_state;

    logic        move_val4, move_rdy4, busy4, move_done4, move_err4, solved4;
    logic [1:0]  move_dir4, blank_row4, blank_col4;
    logic [3:0]  move_count4, rd_idx4, rd_tile4;
    state_e      dbg_state4;

    sliding_puzzle u_dut (
        .clk(clk), .reset(reset), .move_val(move_val), .move_dir(move_dir),
        .move_rdy(move_rdy), .scr_start(scr_start), .scr_len(scr_len),
        .scr_seed(scr_seed), .busy(busy), .move_done(move_done), .move_err(move_err),
        .solved(solved), .move_count(move_count), .blank_row(blank_row),
        .blank_col(blank_col), .rd_idx(rd_idx), .rd_tile(rd_tile), .dbg_state(dbg_state)
    );

    sliding_puzzle #(.DIM(4), .CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .move_val(move_val4), .move_dir(move_dir4),
        .move_rdy(move_rdy4), .scr_start(1'b0), .scr_len(8'd0),
        .scr_seed(16'd0), .busy(busy4), .move_done(move_done4), .move_err(move_err4),
        .solved(solved4), .move_count(move_count4), .blank_row(blank_row4),
        .blank_col(blank_col4), .rd_idx(rd_idx4), .rd_tile(rd_tile4), .dbg_state(dbg_state4)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the 3x3 board as a plain array of tile numbers.
    int m_board[9];
    int m_br, m_bc, m_cnt;
    int saved[9];

    function automatic void m_reset();
        for (int i = 0; i < 9; i++) m_board[i] = (i == 8) ? 0 : i + 1;
        m_br  = 2;
        m_bc  = 2;
        m_cnt = 0;
    endfunction

    function automatic bit m_legal(input int dir);
        case (dir)
            0:       return m_bc > 0;
            1:       return m_bc < 2;
            2:       return m_br > 0;
            default: return m_br < 2;
        endcase
    endfunction

    function automatic void m_apply(input int dir);
        int nr, nc, tmp;
        nr = m_br;
        nc = m_bc;
        case (dir)
            0:       nc = m_bc - 1;
            1:       nc = m_bc + 1;
            2:       nr = m_br - 1;
            default: nr = m_br + 1;
        endcase
        tmp                    = m_board[nr * 3 + nc];
        m_board[nr * 3 + nc]   = 0;
        m_board[m_br * 3 + m_bc] = tmp;
        m_br = nr;
        m_bc = nc;
    endfunction

    function automatic bit m_solved();
        for (int i = 0; i < 9; i++) begin
            if (m_board[i] != ((i == 8) ? 0 : i + 1)) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int opposite(input int dir);
        case (dir)
            0:       return 1;
            1:       return 0;
            2:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Applies a whole scramble to the model; returns the number of LFSR steps taken.
    function automatic int m_scramble(input int len, input logic [15:0] seed);
        logic [15:0] s;
        int prev, rem, steps, d;
        s     = (seed == 16'd0) ? 16'hACE1 : seed;
        prev  = -1;
        rem   = len;
        steps = 0;
        while (rem > 0 && steps < 100000) begin
            d = int'(s[1:0]);
            if (m_legal(d) && !(prev >= 0 && d == opposite(prev))) begin
                m_apply(d);
                prev = d;
                rem--;
            end
            s = lfsr_next(s);
            steps++;
        end
        m_cnt = 0;
        return steps;
    endfunction

    task automatic check_board(input string tag);
        for (int i = 0; i < 9; i++) begin
            rd_idx = 4'(i);
            #1;
            check(tag, 32'(rd_tile), 32'(m_board[i]));
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, "_row"}, 32'(blank_row), 32'(m_br));
        check({tag, "_col"}, 32'(blank_col), 32'(m_bc));
        check({tag, "_count"}, 32'(move_count), 32'(m_cnt));
        check({tag, "_solved"}, 32'(solved), 32'(m_solved()));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_reset();
    endtask

    task automatic user_move(input int dir);
        bit lg;
        @(negedge clk);
        move_val = 1'b1;
        move_dir = 2'(dir);
        @(negedge clk);
        move_val = 1'b0;
        lg = m_legal(dir);
        if (lg) begin
            m_apply(dir);
            if (m_cnt < 65535) m_cnt++;
        end
        check("move_done", 32'(move_done), 32'(lg));
        check("move_err", 32'(move_err), 32'(!lg));
        check_status("move");
        check_board("move_cell");
    endtask

    task automatic run_scramble(input int len, input logic [15:0] seed, input bit noise);
        int exp_steps, busy_cyc, swaps, pulses, guard, mask;
        logic [1:0] pr, pc;
        @(negedge clk);
        pr        = blank_row;
        pc        = blank_col;
        scr_start = 1'b1;
        scr_len   = 8'(len);
        scr_seed  = seed;
        move_val  = 1'b1;
        move_dir  = 2'($urandom_range(0, 3));
        exp_steps = m_scramble(len, seed);
        @(negedge clk);
        scr_start = 1'b0;
        if (!noise) move_val = 1'b0;
        check("scr_busy", 32'(busy), 32'd1);
        check("scr_rdy", 32'(move_rdy), 32'd0);
        check("scr_state", 32'(dbg_state), 32'(ST_SCRAMBLE));
        busy_cyc = 0;
        swaps    = 0;
        pulses   = 0;
        guard    = 0;
        while (guard < 4000) begin
            if (blank_row != pr || blank_col != pc) swaps++;
            pr = blank_row;
            pc = blank_col;
            if (move_done || move_err) pulses++;
            if (!busy) break;
            busy_cyc++;
            scr_start = noise && (busy_cyc == 3);
            if (scr_start) begin
                scr_len  = 8'($urandom_range(1, 255));
                scr_seed = 16'($urandom);
            end
            @(negedge clk);
            guard++;
        end
        scr_start = 1'b0;
        move_val  = 1'b0;
        check("scr_bounded", 32'(guard < 4000), 32'd1);
        check("scr_cycles", 32'(busy_cyc), 32'(exp_steps));
        check("scr_swaps", 32'(swaps), 32'(len));
        check("scr_pulses", 32'(pulses), 32'd0);
        check("scr_rdy_end", 32'(move_rdy), 32'd1);
        check_status("scr");
        check_board("scr_cell");
        mask = 0;
        for (int i = 0; i < 9; i++) begin
            rd_idx = 4'(i);
            #1;
            mask = mask | (1 << int'(rd_tile));
        end
        check("scr_perm", 32'(mask), 32'h1FF);
    endtask

    initial begin
        #2ms;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        move_val  = 1'b0;
        move_dir  = 2'd0;
        scr_start = 1'b0;
        scr_len   = 8'd0;
        scr_seed  = 16'd0;
        rd_idx    = 4'd0;
        move_val4 = 1'b0;
        move_dir4 = 2'd0;
        rd_idx4   = 4'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_reset();

        // Reset state and out-of-range reads.
        check_board("rst_cell");
        check_status("rst");
        check("rst_rdy", 32'(move_rdy), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(move_done), 32'd0);
        check("rst_err", 32'(move_err), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_PLAY));
        for (int i = 9; i < 16; i++) begin
            rd_idx = 4'(i);
            #1;
            check("rd_oob", 32'(rd_tile), 32'd0);
        end

        user_move(1);
        user_move(0);
        user_move(1);

        do_reset();
        user_move(2);
        user_move(2);
        user_move(2);

        // Zero-length scramble is ignored, so the same-cycle move goes through.
        @(negedge clk);
        scr_start = 1'b1;
        scr_len   = 8'd0;
        scr_seed  = 16'h5555;
        move_val  = 1'b1;
        move_dir  = 2'd0;
        @(negedge clk);
        scr_start = 1'b0;
        move_val  = 1'b0;
        m_apply(0);
        m_cnt++;
        check("len0_busy", 32'(busy), 32'd0);
        check("len0_done", 32'(move_done), 32'd1);
        check_status("len0");

        for (int k = 0; k < 80; k++) user_move($urandom_range(0, 3));

        do_reset();
        run_scramble(20, 16'h0001, 1'b0);
        for (int i = 0; i < 9; i++) saved[i] = m_board[i];
        for (int k = 0; k < 10; k++) user_move($urandom_range(0, 3));
        do_reset();
        run_scramble(20, 16'h0001, 1'b1);
        for (int i = 0; i < 9; i++) begin
            rd_idx = 4'(i);
            #1;
            check("scr_repeat", 32'(rd_tile), 32'(saved[i]));
        end
        run_scramble(10, 16'h0000, 1'b0);
        run_scramble($urandom_range(1, 60), 16'($urandom_range(1, 65535)), 1'b0);
        for (int k = 0; k < 5; k++) user_move($urandom_range(0, 3));

        // Reset in the middle of a scramble.
        @(negedge clk);
        scr_start = 1'b1;
        scr_len   = 8'd50;
        scr_seed  = 16'h1234;
        @(negedge clk);
        scr_start = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_reset();
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_rdy", 32'(move_rdy), 32'd1);
        check_status("mid");
        check_board("mid_cell");

        // 4x4 board: reset layout and move counter saturation at 15.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            rd_idx4 = 4'(i);
            #1;
            check("d4_rst_cell", 32'(rd_tile4), (i == 15) ? 32'd0 : 32'(i + 1));
        end
        check("d4_solved", 32'(solved4), 32'd1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            move_val4 = 1'b1;
            move_dir4 = (k % 2 == 0) ? 2'd0 : 2'd1;
            @(negedge clk);
            move_val4 = 1'b0;
            check("d4_done", 32'(move_done4), 32'd1);
            check("d4_count", 32'(move_count4), (k + 1 > 15) ? 32'd15 : 32'(k + 1));
        end
        check("d4_solved_end", 32'(solved4), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
